cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between ICache refill and DCache refill/writeback bursts.
- Each grant covers one whole cache-line burst. Beat addresses are generated internally.
- Produces the ICacheMiss/DCacheMiss stall-level signals consumed by the hazard unit.
- Sits between the two caches and the memory model, inside the CPU core.

Parameters:
- LINE_WORDS, 8, words per cache line. Power of two, 2..64.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- CpuRst  in  1  synchronous, active-high reset.
- i_req  in  1  ICache line-refill request. Held high until i_done.
- i_addr  in  ADDR_W  ICache line address. Low offset bits ignored.
- i_rvalid  out  1  ICache refill data beat valid.
- i_rdata  out  DATA_W  ICache refill data.
- i_done  out  1  one-cycle pulse when the ICache burst completes.
- d_req  in  1  DCache request. Held high until d_done.
- d_we  in  1  1 = writeback burst, 0 = refill burst. Sampled at grant.
- d_addr  in  ADDR_W  DCache line address.
- d_wdata  in  DATA_W  writeback word selected by d_wbeat (combinational from the cache).
- d_wbeat  out  log2(LINE_WORDS)  index of the beat currently being issued.
- d_rvalid  out  1  DCache refill data beat valid.
- d_rdata  out  DATA_W  DCache refill data.
- d_done  out  1  one-cycle pulse when the DCache burst completes.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  DATA_W  write data (= d_wdata).
- mem_ready  in  1  memory accepts the beat this cycle when mem_req & mem_ready.
- mem_rvalid  in  1  read data beat returned. In order, any latency ≥1.
- mem_rdata  in  DATA_W  read data.
- ICacheMiss  out  1  i_req & ~i_done.
- DCacheMiss  out  1  d_req & ~d_done.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; owner register 0.
- States: IDLE, XFER_I, XFER_D, DONE.
- IDLE:
  - d_req wins over i_req (fixed priority).
  - Latch owner, the line address (offset bits cleared) and d_we.
  - Go to XFER_I/XFER_D next cycle. mem_req first rises in the XFER cycle, giving a 1-cycle grant latency.
- XFER:
  - mem_req = 1 while issue_cnt < LINE_WORDS.
  - mem_addr = {line_addr[ADDR_W-1:OFF], issue_cnt, 2'b00}, where OFF = log2(LINE_WORDS)+2.
  - mem_we = latched d_we in XFER_D, else 0.
  - d_wbeat = issue_cnt.
  - issue_cnt increments on mem_req & mem_ready.
- Read bursts:
  - Each mem_rvalid is routed combinationally to the owner's x_rvalid/x_rdata in the same cycle.
  - ret_cnt increments on each mem_rvalid.
  - When ret_cnt reaches LINE_WORDS-1 and mem_rvalid = 1, go to DONE.
- Write bursts: go to DONE on the cycle the last beat is accepted. mem_rvalid is ignored.
- mem_rvalid outside a read XFER (including after a reset mid-burst) is ignored; no rvalid goes to either cache.
- DONE:
  - Owner's x_done = 1 for exactly one cycle, registered.
  - Counters clear. Return to IDLE.
  - Requests are not arbitrated in DONE. This prevents a stale req from re-granting before the cache drops it.
- Minimum spacing between consecutive grants: 1 idle cycle (the DONE cycle).
- A request change during XFER (req dropped, or address/d_we change) has no effect; the burst always runs to completion.
- CpuRst mid-burst: next cycle is IDLE with counters cleared, mem_req = 0 and no done pulse.
- The counters are one bit wider than log2(LINE_WORDS), so they have no wrap-around.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register (reset value = I) biases arbitration.
  - When both requests are present in IDLE, the requester that did not own the previous grant wins.
  - A single request is always granted.
- Undefined: fixed DCache priority as above; last_owner is not instantiated.

Test Plan:
- Single ICache refill:
  - Stimulus: i_addr = 0x0000_1234, LINE_WORDS = 8, mem_ready = 1, rvalid 2 cycles after acceptance.
  - Required: mem_addr 0x1220..0x123C in order, 8 i_rvalid beats, i_done 1 cycle after the 8th rvalid, ICacheMiss high throughout then low.
- DCache writeback:
  - Stimulus: d_we = 1, d_addr = 0x2000, mem_ready toggling 1/0.
  - Required: 8 write beats at 0x2000..0x201C, each issued with d_wbeat = beat index; d_done in the cycle after the last acceptance; no d_rvalid.
- Simultaneous requests:
  - Stimulus: i_req and d_req rise in the same cycle.
  - Required: D burst first, then 1 DONE cycle, then I granted in the following IDLE.
  - With ARB_ROUND_ROBIN_EN and previous owner D: I is granted first.
- Back-to-back same requester:
  - Stimulus: i_req held one cycle past i_done.
  - Required: no second grant; mem_req stays 0 for that cycle.
- Reset mid-burst:
  - Stimulus: CpuRst asserted after 3 beats, then 2 stray mem_rvalid pulses.
  - Required: mem_req = 0 the next cycle, no i_rvalid/i_done, state IDLE.
  - A new i_req after reset starts again at beat 0.
- Backpressure:
  - Stimulus: mem_ready = 0 for 5 cycles mid-burst.
  - Required: mem_addr holds and issue_cnt holds; burst completes with exactly 8 beats.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache/memory bus bundle for the line-burst arbiter
// Ports (signals): ICache refill side (i_*), DCache refill/writeback side (d_*),
// single main-memory beat port (mem_*).
// Modport master = arbiter side, modport slave = caches and memory model side.
interface cache_mem_arbiter_if #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    localparam int BW = $clog2(LINE_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BW-1:0]     d_wbeat;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output i_rvalid, i_rdata, i_done,
        output d_wbeat, d_rvalid, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  i_rvalid, i_rdata, i_done,
        input  d_wbeat, d_rvalid, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between ICache and DCache line bursts
// Ports: clk (core clock), CpuRst (sync active-high reset), bus (cache_mem_arbiter_if.master:
// cache requests, refill data, done pulses, memory beat port), ICacheMiss / DCacheMiss
// (stall levels for the hazard unit).
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner when both caches request at once;
// otherwise the DCache always wins.
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    CpuRst,
    cache_mem_arbiter_if.master     bus,
    output logic                    ICacheMiss,
    output logic                    DCacheMiss
);
    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFF = CW + 2;

    // Counters carry one extra bit so "all beats issued" is a distinct value.
    localparam logic [CW:0] CNT_LINE = (CW+1)'(LINE_WORDS);
    localparam logic [CW:0] CNT_LAST = (CW+1)'(LINE_WORDS - 1);
    localparam logic [CW:0] CNT_ONE  = (CW+1)'(1);

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {IDLE, XFER_I, XFER_D, DONE} state_t;

    state_t                 state;
    logic                   owner;
    logic                   we_lat;
    logic [ADDR_W-OFF-1:0]  line_tag;
    logic [CW:0]            issue_cnt;
    logic [CW:0]            ret_cnt;
    logic                   i_done_r;
    logic                   d_done_r;

    logic in_xfer, rd_burst, issue, accept, grant_d;

    assign in_xfer  = (state == XFER_I) || (state == XFER_D);
    assign rd_burst = (state == XFER_I) || ((state == XFER_D) && !we_lat);
    assign issue    = in_xfer && (issue_cnt < CNT_LINE);
    assign accept   = issue && bus.mem_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;
    // On a tie the cache that did not win last time goes first.
    assign grant_d = bus.d_req && (!bus.i_req || (last_owner == OWNER_I));
`else
    assign grant_d = bus.d_req;
`endif

    assign bus.mem_req   = issue;
    assign bus.mem_we    = (state == XFER_D) && we_lat;
    assign bus.mem_addr  = {line_tag, issue_cnt[CW-1:0], 2'b00};
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.d_wbeat   = issue_cnt[CW-1:0];

    // Read data is steered to the owner in the same cycle; anything arriving
    // outside a read burst (e.g. leftovers after a reset) is dropped.
    assign bus.i_rvalid = (state == XFER_I) && bus.mem_rvalid;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rvalid = (state == XFER_D) && !we_lat && bus.mem_rvalid;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    assign bus.i_done   = i_done_r;
    assign bus.d_done   = d_done_r;

    assign ICacheMiss = bus.i_req & ~i_done_r;
    assign DCacheMiss = bus.d_req & ~d_done_r;

    logic unused_bits;
    assign unused_bits = ^{bus.i_addr[OFF-1:0], bus.d_addr[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state     <= IDLE;
            owner     <= OWNER_I;
            we_lat    <= 1'b0;
            line_tag  <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            i_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWNER_I;
`endif
        end else begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.d_req || bus.i_req) begin
                        owner    <= grant_d ? OWNER_D : OWNER_I;
                        line_tag <= grant_d ? bus.d_addr[ADDR_W-1:OFF]
                                            : bus.i_addr[ADDR_W-1:OFF];
                        we_lat   <= grant_d && bus.d_we;
                        state    <= grant_d ? XFER_D : XFER_I;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= grant_d ? OWNER_D : OWNER_I;
`endif
                    end
                end
                XFER_I, XFER_D: begin
                    if (accept)
                        issue_cnt <= issue_cnt + CNT_ONE;
                    if (rd_burst) begin
                        if (bus.mem_rvalid) begin
                            ret_cnt <= ret_cnt + CNT_ONE;
                            if (ret_cnt == CNT_LAST) begin
                                state    <= DONE;
                                i_done_r <= (owner == OWNER_I);
                                d_done_r <= (owner == OWNER_D);
                            end
                        end
                    end else if (accept && (issue_cnt == CNT_LAST)) begin
                        state    <= DONE;
                        d_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    // No arbitration here: the finished cache still holds its
                    // request this cycle and must not be granted again.
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic CpuRst;
    logic ICacheMiss, DCacheMiss;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.LINE_WORDS(8), .ADDR_W(32), .DATA_W(32)) ifc();

    cache_mem_arbiter #(.LINE_WORDS(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .CpuRst     (CpuRst),
        .bus        (ifc),
        .ICacheMiss (ICacheMiss),
        .DCacheMiss (DCacheMiss)
    );

    // Writeback data the cache presents for the selected beat.
    assign ifc.d_wdata = 32'hDA7A_0000 + {29'd0, ifc.d_wbeat};

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        int          mode;   // 0 ready always, 1 ready toggles, 2 five-cycle stall
        logic [31:0] base;
        int          irv;
        int          drv;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, start_cyc = 0, ready_mode = 0;
    int acc_n, wr_n, req_n, irv_n, drv_n, idone_n, ddone_n, imiss_n, dmiss_n;
    int idone_cyc, ddone_cyc, last_rv_cyc, last_acc_cyc, first_req_cyc;
    int err_wdata, err_rdata, err_hold;
    logic [31:0] acc_addr[$];
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        pv[2];
    logic [31:0] pd[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        acc_n = 0; wr_n = 0; req_n = 0; irv_n = 0; drv_n = 0;
        idone_n = 0; ddone_n = 0; imiss_n = 0; dmiss_n = 0;
        idone_cyc = -1; ddone_cyc = -1; last_rv_cyc = -1; last_acc_cyc = -1;
        first_req_cyc = -1; err_wdata = 0; err_rdata = 0; err_hold = 0;
        prev_stall = 1'b0; prev_addr = '0;
        acc_addr.delete();
    endtask

    function automatic logic ready_fn();
        int rel;
        rel = cyc - start_cyc;
        case (ready_mode)
            1:       return rel[0];
            2:       return !(rel >= 3 && rel < 8);
            default: return 1'b1;
        endcase
    endfunction

    // Observe the current cycle at the falling edge, then move to the next
    // cycle and drive the memory model's inputs just after the rising edge.
    task automatic tick();
        logic acc;
        @(negedge clk);
        if (prev_stall && ifc.mem_addr !== prev_addr) err_hold++;
        prev_stall = ifc.mem_req & ~ifc.mem_ready;
        prev_addr  = ifc.mem_addr;
        acc = ifc.mem_req & ifc.mem_ready;
        if (ifc.mem_req) begin
            req_n++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (acc) begin
            acc_n++;
            acc_addr.push_back(ifc.mem_addr);
            last_acc_cyc = cyc;
            if (ifc.mem_we) begin
                wr_n++;
                if (ifc.d_wbeat !== ifc.mem_addr[4:2] ||
                    ifc.mem_wdata !== 32'hDA7A_0000 + {29'd0, ifc.mem_addr[4:2]})
                    err_wdata++;
            end
        end
        if (ifc.i_rvalid) begin
            irv_n++; last_rv_cyc = cyc;
            if (ifc.i_rdata !== ifc.mem_rdata) err_rdata++;
        end
        if (ifc.d_rvalid) begin
            drv_n++; last_rv_cyc = cyc;
            if (ifc.d_rdata !== ifc.mem_rdata) err_rdata++;
        end
        if (ifc.i_done) begin idone_n++; idone_cyc = cyc; end
        if (ifc.d_done) begin ddone_n++; ddone_cyc = cyc; end
        if (ICacheMiss) imiss_n++;
        if (DCacheMiss) dmiss_n++;
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = acc & ~ifc.mem_we;
        pd[0] = ifc.mem_addr ^ 32'h5A5A_0000;
        @(posedge clk);
        #1;
        cyc++;
        ifc.mem_ready  = ready_fn();
        ifc.mem_rvalid = pv[1];
        ifc.mem_rdata  = pv[1] ? pd[1] : 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s, done_cyc, ref_cyc, post0;
        clear_obs();
        s = cyc; start_cyc = cyc; ready_mode = v.mode;
        if (v.is_d) begin
            ifc.d_req = 1'b1; ifc.d_we = v.we; ifc.d_addr = v.addr;
        end else begin
            ifc.i_req = 1'b1; ifc.i_addr = v.addr;
        end
        for (int k = 0; k < 200; k++) begin
            tick();
            // Changing the request mid-burst must not disturb the burst.
            if (k == 2) begin
                ifc.i_addr = 32'hFFFF_0000; ifc.d_addr = 32'hEEEE_0000; ifc.d_we = ~v.we;
            end
            if ((v.is_d ? ddone_n : idone_n) != 0) break;
        end
        ifc.i_req = 1'b0; ifc.d_req = 1'b0; ifc.d_we = 1'b0;
        done_cyc = v.is_d ? ddone_cyc : idone_cyc;
        post0 = req_n;
        repeat (3) tick();
        ready_mode = 0;

        check({tag, " done_count"}, v.is_d ? ddone_n : idone_n, 1);
        check({tag, " other_done"}, v.is_d ? idone_n : ddone_n, 0);
        check({tag, " beats"}, acc_n, 8);
        for (int k = 0; k < 8; k++)
            if (acc_addr.size() > k)
                check($sformatf("%s beat%0d_addr", tag, k), acc_addr[k], v.base + 32'(4 * k));
        check({tag, " write_beats"}, wr_n, v.we ? 8 : 0);
        check({tag, " i_rvalid_count"}, irv_n, v.irv);
        check({tag, " d_rvalid_count"}, drv_n, v.drv);
        check({tag, " wdata_wbeat_errs"}, err_wdata, 0);
        check({tag, " rdata_errs"}, err_rdata, 0);
        check({tag, " addr_hold_errs"}, err_hold, 0);
        check({tag, " grant_latency"}, first_req_cyc, s + 1);
        ref_cyc = (v.is_d && v.we) ? last_acc_cyc : last_rv_cyc;
        check({tag, " done_timing"}, done_cyc, ref_cyc + 1);
        check({tag, " miss_cycles"}, v.is_d ? dmiss_n : imiss_n, done_cyc - s);
        check({tag, " other_miss"}, v.is_d ? imiss_n : dmiss_n, 0);
        check({tag, " no_regrant"}, req_n - post0, 0);
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   c1;
    bit   first_d;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{is_d: 0, we: 0, addr: 32'h0000_1234, mode: 0, base: 32'h0000_1220, irv: 8, drv: 0};
        vecs[1] = '{is_d: 1, we: 1, addr: 32'h0000_2000, mode: 1, base: 32'h0000_2000, irv: 0, drv: 0};
        vecs[2] = '{is_d: 1, we: 0, addr: 32'hFFFF_FFFF, mode: 0, base: 32'hFFFF_FFE0, irv: 0, drv: 8};
        vecs[3] = '{is_d: 0, we: 0, addr: 32'h0000_8010, mode: 2, base: 32'h0000_8000, irv: 8, drv: 0};
        vecs[4] = '{is_d: 1, we: 1, addr: 32'h0000_207C, mode: 2, base: 32'h0000_2060, irv: 0, drv: 0};

        CpuRst = 1'b1;
        ifc.i_req = 0; ifc.i_addr = 0; ifc.d_req = 0; ifc.d_we = 0; ifc.d_addr = 0;
        ifc.mem_ready = 0; ifc.mem_rvalid = 0; ifc.mem_rdata = 0;
        pv[0] = 0; pv[1] = 0; pd[0] = 0; pd[1] = 0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {ifc.mem_req, ifc.mem_we, ifc.i_rvalid, ifc.i_done,
                             ifc.d_rvalid, ifc.d_done, ICacheMiss, DCacheMiss}, 8'h00);
        check("reset_mem_addr", ifc.mem_addr, 32'h0);
        check("reset_wbeat", ifc.d_wbeat, 3'd0);
        check("reset_rdata", {ifc.i_rdata, ifc.d_rdata}, 64'h0);
        CpuRst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests; previous grant went to the DCache.
        clear_obs();
        ifc.i_req = 1; ifc.i_addr = 32'h0000_5000;
        ifc.d_req = 1; ifc.d_we = 0; ifc.d_addr = 32'h0000_4000;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (idone_n + ddone_n != 0) break;
        end
        first_d = (ddone_n != 0);
`ifdef ARB_ROUND_ROBIN_EN
        check("sim_first_owner_d", first_d, 1'b0);
`else
        check("sim_first_owner_d", first_d, 1'b1);
`endif
        c1 = first_d ? ddone_cyc : idone_cyc;
        if (first_d) ifc.d_req = 0; else ifc.i_req = 0;
        first_req_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (idone_n != 0 && ddone_n != 0) break;
        end
        ifc.i_req = 0; ifc.d_req = 0;
        tick();
        check("sim_second_grant_cycle", first_req_cyc, c1 + 2);
        check("sim_beats", acc_n, 16);
        if (acc_addr.size() >= 16) begin
            check("sim_first_base", acc_addr[0], first_d ? 32'h4000 : 32'h5000);
            check("sim_second_base", acc_addr[8], first_d ? 32'h5000 : 32'h4000);
        end
        check("sim_rvalids", {irv_n[7:0], drv_n[7:0]}, {8'd8, 8'd8});

        // Reset after three accepted beats, then stray read returns.
        clear_obs();
        ifc.i_req = 1; ifc.i_addr = 32'h0000_6040;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_n >= 3) break;
        end
        CpuRst = 1; ifc.i_req = 0;
        tick();
        CpuRst = 0;
        clear_obs();
        ifc.mem_rvalid = 1; ifc.mem_rdata = 32'h0000_57A7;
        tick();
        ifc.mem_rvalid = 1; ifc.mem_rdata = 32'h0000_57A8;
        repeat (4) tick();
        check("rst_mem_req", req_n, 0);
        check("rst_i_rvalid", irv_n, 0);
        check("rst_done", idone_n + ddone_n, 0);
        rv = '{is_d: 0, we: 0, addr: 32'h0000_6040, mode: 0, base: 32'h0000_6040, irv: 8, drv: 0};
        run_vec(rv, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
